// File: rtl/cic_mux_filter_if.sv
// Sequencer-strobe and PCM-stream bundle of cic_mux_filter.
interface cic_mux_filter_if #(
  parameter int CHANNELS       = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int CHANNELS_WIDTH = $clog2(CHANNELS)
);
  // pcm_valid is a one-cycle strobe with no ready: pcm_data, pcm_channel and
  // cic_finish are meaningful only while pcm_valid=1 and must be taken then.
  logic [CHANNELS-1:0]       pdm_data;
  logic                      read_enable;
  logic                      integrator_enable;
  logic                      comb_enable;
  logic [CHANNELS_WIDTH-1:0] channel;
  logic                      cic_finish;
  logic [DATA_WIDTH-1:0]     pcm_data;
  logic [CHANNELS_WIDTH-1:0] pcm_channel;
  logic                      pcm_valid;
  logic                      dbg_phase;

  modport master (
    output pdm_data, read_enable, integrator_enable, comb_enable,
    input  channel, cic_finish, pcm_data, pcm_channel, pcm_valid, dbg_phase
  );

  modport slave (
    input  pdm_data, read_enable, integrator_enable, comb_enable,
    output channel, cic_finish, pcm_data, pcm_channel, pcm_valid, dbg_phase
  );
endinterface

// File: rtl/cic_mux_filter.sv
// Time-multiplexed CIC decimator: one integrator/comb engine shared by all channels.
// Define CIC_SATURATE_EN to clamp the output instead of wrapping it to DATA_WIDTH.
module cic_mux_filter #(
  parameter int CHANNELS       = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int STAGES         = 3,
  parameter int ACC_WIDTH      = 26,
  parameter int OUT_SHIFT      = 10,
  parameter int CHANNELS_WIDTH = $clog2(CHANNELS)
) (
  input logic             clk,
  input logic             resetn,
  cic_mux_filter_if.slave bus
);
  typedef enum logic {PH_COMPUTE = 1'b0, PH_HOLD = 1'b1} phase_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  phase_t                    phase, phase_next;
  acc_t                      integ   [STAGES][CHANNELS];
  acc_t                      comb_d  [STAGES][CHANNELS];
  acc_t                      int_res [STAGES];
  logic [CHANNELS-1:0]       pdm_q;
  logic                      comb_pass;
  logic [CHANNELS_WIDTH-1:0] channel;
  logic [DATA_WIDTH-1:0]     pcm_data;
  logic [CHANNELS_WIDTH-1:0] pcm_channel;
  logic                      pcm_valid;
  logic                      cic_finish;

  logic                      compute_en, hold_en, last_ch;
  acc_t                      x;
  acc_t                      int_calc [STAGES];
  acc_t                      comb_in  [STAGES];
  acc_t                      comb_out [STAGES];
  acc_t                      shifted;
  logic [DATA_WIDTH-1:0]     narrowed;

`ifdef CIC_SATURATE_EN
  localparam int WW = (ACC_WIDTH > DATA_WIDTH) ? ACC_WIDTH : DATA_WIDTH;
  localparam logic signed [WW-1:0] SAT_MAX = WW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [WW-1:0] SAT_MIN = -SAT_MAX - WW'(1);
  logic signed [WW-1:0] wide;
`endif

  assign last_ch = (channel == CHANNELS_WIDTH'(CHANNELS - 1));

  // A read strobe or a dropped integrator_enable always returns to COMPUTE.
  always_comb begin
    phase_next = phase;
    compute_en = 1'b0;
    hold_en    = 1'b0;
    if (bus.read_enable || !bus.integrator_enable) begin
      phase_next = PH_COMPUTE;
    end else begin
      case (phase)
        PH_COMPUTE: begin
          compute_en = 1'b1;
          phase_next = PH_HOLD;
        end
        default: begin
          hold_en    = 1'b1;
          phase_next = PH_COMPUTE;
        end
      endcase
    end
  end

  always_comb begin
    x = pdm_q[channel] ? acc_t'(1) : acc_t'(-1);
    int_calc[0] = integ[0][channel] + x;
    for (int s = 1; s < STAGES; s++) int_calc[s] = integ[s][channel] + int_calc[s-1];
    comb_in[0]  = int_res[STAGES-1];
    comb_out[0] = comb_in[0] - comb_d[0][channel];
    for (int s = 1; s < STAGES; s++) begin
      comb_in[s]  = comb_out[s-1];
      comb_out[s] = comb_in[s] - comb_d[s][channel];
    end
    shifted = comb_out[STAGES-1] >>> OUT_SHIFT;
`ifdef CIC_SATURATE_EN
    wide = WW'(shifted);
    if (wide > SAT_MAX)      narrowed = SAT_MAX[DATA_WIDTH-1:0];
    else if (wide < SAT_MIN) narrowed = SAT_MIN[DATA_WIDTH-1:0];
    else                     narrowed = DATA_WIDTH'(wide);
`else
    narrowed = DATA_WIDTH'(shifted);
`endif
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      phase       <= PH_COMPUTE;
      channel     <= '0;
      pdm_q       <= '0;
      comb_pass   <= 1'b0;
      pcm_data    <= '0;
      pcm_channel <= '0;
      pcm_valid   <= 1'b0;
      cic_finish  <= 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        int_res[s] <= '0;
        for (int c = 0; c < CHANNELS; c++) begin
          integ[s][c]  <= '0;
          comb_d[s][c] <= '0;
        end
      end
    end else begin
      phase      <= phase_next;
      pcm_valid  <= 1'b0;
      cic_finish <= 1'b0;
      if (bus.read_enable) begin
        pdm_q     <= bus.pdm_data;
        comb_pass <= bus.comb_enable;
        channel   <= '0;
      end else if (!bus.integrator_enable) begin
        channel <= '0;
      end else if (compute_en) begin
        int_res <= int_calc;
      end else if (hold_en) begin
        for (int s = 0; s < STAGES; s++) integ[s][channel] <= int_res[s];
        if (comb_pass) begin
          for (int s = 0; s < STAGES; s++) comb_d[s][channel] <= comb_in[s];
          pcm_data    <= narrowed;
          pcm_channel <= channel;
          pcm_valid   <= 1'b1;
          cic_finish  <= last_ch;
        end
        channel <= last_ch ? '0 : channel + 1'b1;
      end
    end
  end

  assign bus.channel     = channel;
  assign bus.dbg_phase   = phase;
  assign bus.pcm_data    = pcm_data;
  assign bus.pcm_channel = pcm_channel;
  assign bus.pcm_valid   = pcm_valid;
  assign bus.cic_finish  = cic_finish;
endmodule

// File: doc/cic_mux_filter.md
# cic_mux_filter

Time-multiplexed CIC decimation datapath for the microphone array: one shared integrator/comb engine serves all channels, stepping through them under the strobes issued by the CIC sequencer (`read_enable`, `integrator_enable`, `comb_enable`). It returns the channel index the sequencer uses to end each pass and emits one PCM word per channel per decimated frame to the downstream FIFO/bus stage.

## Interface
- `CHANNELS`, 8, microphone channels; PDM bits per frame.
- `DATA_WIDTH`, 16, PCM output width.
- `STAGES`, 3, CIC order (integrator and comb stage count).
- `ACC_WIDTH`, 26, integrator/comb word width; must be ≥ STAGES·ceil(log2(max R))+2.
- `OUT_SHIFT`, 10, arithmetic right shift applied to the comb output before narrowing.
- `CHANNELS_WIDTH`, $clog2(CHANNELS), channel index width.
- `clk` in 1: system clock.
- `resetn` in 1: reset, **synchronous, active-high** (despite the name).
- `pdm_data` in CHANNELS: PDM bits, one per mic; valid while `read_enable`=1.
- `read_enable` in 1: one-cycle strobe; capture `pdm_data` and start a pass.
- `integrator_enable` in 1: high for 2·CHANNELS cycles per pass.
- `comb_enable` in 1: level; high for the whole PDM period of a decimation frame.
- `channel` out CHANNELS_WIDTH: channel currently being processed.
- `cic_finish` out 1: one-cycle pulse with the last channel's output of a decimated frame.
- `pcm_data` out DATA_WIDTH: signed PCM sample.
- `pcm_channel` out CHANNELS_WIDTH: channel of `pcm_data`.
- `pcm_valid` out 1: one-cycle strobe qualifying `pcm_data`/`pcm_channel`.

## Operation
- Storage: integrator I[s][c] and comb delay D[s][c], STAGES×CHANNELS words of ACC_WIDTH; capture register `pdm_q`; flag `comb_pass`; `phase` bit.
- Input mapping: bit 1 → +1, bit 0 → −1, sign-extended to ACC_WIDTH.
- `read_enable`=1: `pdm_q`←`pdm_data`, `comb_pass`←`comb_enable`, `channel`←0, `phase`←0. Takes precedence over everything else; an in-flight phase-0 result is discarded.
- While `integrator_enable`=1, `phase` toggles each cycle:
  - COMPUTE (phase 0): cascade for channel c with updated values: I0'=I0+x, Is'=Is+I(s−1)'. Register the results.
  - HOLD (phase 1): write I'[*][c]. If `comb_pass`: comb cascade on I'(STAGES−1): y0=in−D0, ys=y(s−1)−Ds; Ds←stage input; register output. `channel` increments at the end of HOLD and wraps CHANNELS−1→0.
- `channel` therefore equals c for both cycles of c's slot, as the sequencer requires to detect the last channel.
- Output: y>>>OUT_SHIFT (arithmetic), narrowed to DATA_WIDTH per Configuration.
- All arithmetic wraps modulo 2^ACC_WIDTH. The wrap is required for CIC correctness; no overflow detection.
- `integrator_enable` falling while `phase`=0: no writeback; `phase`←0, `channel`←0.

## Timing
- Reset values: `channel`=0, `pcm_data`=0, `pcm_channel`=0, `pcm_valid`=0, `cic_finish`=0, `phase`=0, `comb_pass`=0, all I/D=0, `pdm_q`=0.
- `pcm_valid` is high the cycle after HOLD of channel c (latency 2 cycles from c's COMPUTE), with `pcm_channel`=c.
- `cic_finish` coincides with `pcm_valid` for c=CHANNELS−1 only.
- Per comb pass: exactly CHANNELS `pcm_valid` pulses, channels 0..CHANNELS−1 in order. A non-comb pass produces none.
- Reset asserted mid-pass: all state cleared on that edge, with no partial outputs.
- First STAGES decimated outputs per channel are start-up transient.

## Configuration
- `CIC_SATURATE_EN` defined: the shifted value is clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- `CIC_SATURATE_EN` undefined: the low DATA_WIDTH bits are kept (two's-complement wrap), with no clamp logic.

## Test plan
- Reset: drive random strobes with `resetn`=1, then release. All outputs are 0 and `channel`=0 until the first `read_enable`.
- Sequencing: CHANNELS=8, comb every frame. Per pass: `channel` holds k for 2 cycles, k=0..7. Eight `pcm_valid` pulses with `pcm_channel` 0..7. `cic_finish` fires only with channel 7.
- DC response: R=4 (comb every 4th frame), STAGES=3, OUT_SHIFT=0, ch0 all ones, others all zeros. After start-up, ch0 `pcm_data`=64 and ch1..7 =−64 every decimated frame.
- Saturation: DATA_WIDTH=8, R=8, OUT_SHIFT=0, all ones then all zeros. With the macro: 127 / −128. Without it: 0 / 0 (512 mod 256).
- Wrap: ACC_WIDTH=10, R=4, all ones for 1000 frames. Integrators wrap, yet `pcm_data` stays 64.
- Interruption: `read_enable` during ch3 COMPUTE restarts at ch0 with no ch3 output. `resetn` mid-pass clears everything, and the next pass matches the post-reset golden model.
